// File: rtl/ray_dir_generator_pkg.sv
// Shared types and constants for the camera-side ray direction generator.
//   ray_direction_t : unnormalized {x,y,z} direction, WIDTH-bit fixed point per component
//   raygen_state_t  : sweep controller state
//   max_u()         : elaboration-time helper for accumulator sizing
package ray_dir_generator_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned Q_BITS = 12;

  localparam logic [WIDTH-1:0] MAX_16 = 16'h7FFF;
  localparam logic [WIDTH-1:0] MIN_16 = 16'h8000;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } ray_direction_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } raygen_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ray_dir_generator_axis.sv
// ray_axis_stepper: one image-plane axis of the raster sweep.
// Index counter plus signed step accumulator with load / advance / hold, and a
// WIDTH-bit output saturated to [Min, Max].
//   clk, reset : clock, asynchronous active-low reset (clears index and accumulator)
//   load       : restart the axis at index 0 / Init this cycle
//   adv        : advance one position; at index Count-1 wraps back to 0 / Init
//   idx        : index of the current position
//   last       : current position is index Count-1
//   value      : saturated current accumulator value
// 'load' is applied combinationally ahead of 'adv' so the same cycle can both
// restart the axis and emit/advance past position 0.
module ray_axis_stepper
  import ray_dir_generator_pkg::*;
#(
  parameter int unsigned            Count = 64,
  parameter int unsigned            AccW  = 23,
  parameter logic signed [AccW-1:0] Init  = '0,
  parameter logic signed [AccW-1:0] Step  = '0,
  parameter logic [WIDTH-1:0]       Max   = MAX_16,
  parameter logic [WIDTH-1:0]       Min   = MIN_16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       adv,
  output logic [$clog2(Count)-1:0]   idx,
  output logic                       last,
  output logic [WIDTH-1:0]           value
);

  localparam int unsigned IdxW = $clog2(Count);

  localparam logic signed [AccW-1:0] MaxExt = {{(AccW - WIDTH){Max[WIDTH-1]}}, Max};
  localparam logic signed [AccW-1:0] MinExt = {{(AccW - WIDTH){Min[WIDTH-1]}}, Min};

  logic [IdxW-1:0]        idx_q, idx_d, idx_base;
  logic signed [AccW-1:0] acc_q, acc_d, acc_base;

  always_comb begin
    idx_base = load ? '0 : idx_q;
    acc_base = load ? Init : acc_q;
    last     = (idx_base == IdxW'(Count - 1));
    idx_d    = idx_base;
    acc_d    = acc_base;
    if (adv) begin
      if (last) begin
        idx_d = '0;
        acc_d = Init;
      end else begin
        idx_d = idx_base + IdxW'(1);
        acc_d = acc_base + Step;
      end
    end
  end

  always_comb begin
    if (acc_base > MaxExt) begin
      value = Max;
    end else if (acc_base < MinExt) begin
      value = Min;
    end else begin
      value = acc_base[WIDTH-1:0];
    end
  end

  assign idx = idx_base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ray_dir_generator.sv
// ray_dir_generator: sweeps a pinhole image plane in raster order and emits one
// unnormalized direction per pixel straight into the normalizer (start/ray_in).
// Step accumulators only; one ray per cycle while enable is high.
//   clk         : clock
//   reset       : asynchronous active-low reset; aborts a frame without frame_done
//   frame_start : begin a frame (honoured only when idle)
//   enable      : issue permission; low stalls the sweep in place
//   start_out   : ray_out valid this cycle
//   ray_out     : {x, y, z} direction, z = -FOCAL
//   busy        : high from frame accept until frame_done
//   frame_done  : one-cycle pulse the cycle after the last ray
//   pixel_x/y   : column/row of ray_out (only with RAYGEN_PIXEL_TAG_EN defined)
// Optional feature macro: RAYGEN_PIXEL_TAG_EN.
module ray_dir_generator
  import ray_dir_generator_pkg::*;
#(
  parameter int unsigned      IMG_W = 64,
  parameter int unsigned      IMG_H = 48,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(1 << (Q_BITS - 6)),
  parameter logic [WIDTH-1:0] FOCAL = WIDTH'(1 << Q_BITS),
  parameter logic [WIDTH-1:0] MAX   = MAX_16,
  parameter logic [WIDTH-1:0] MIN   = MIN_16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       enable,
  output logic                       start_out,
  output ray_direction_t             ray_out,
  output logic                       busy,
  output logic                       frame_done
`ifdef RAYGEN_PIXEL_TAG_EN
  ,
  output logic [$clog2(IMG_W)-1:0]   pixel_x,
  output logic [$clog2(IMG_H)-1:0]   pixel_y
`endif
);

  localparam int unsigned ACC_W = WIDTH + $clog2(max_u(IMG_W, IMG_H)) + 1;
  localparam int unsigned XW    = $clog2(IMG_W);
  localparam int unsigned YW    = $clog2(IMG_H);

  // Plane is centred on the optical axis: x runs left to right, y top to bottom.
  localparam int X_SPAN = (int'(IMG_W) - 1) * int'(STEP);
  localparam int Y_SPAN = (int'(IMG_H) - 1) * int'(STEP);

  localparam logic signed [ACC_W-1:0] X0     = ACC_W'(-(X_SPAN >>> 1));
  localparam logic signed [ACC_W-1:0] Y0     = ACC_W'(Y_SPAN >>> 1);
  localparam logic signed [ACC_W-1:0] X_STEP = ACC_W'(int'(STEP));
  localparam logic signed [ACC_W-1:0] Y_STEP = ACC_W'(-int'(STEP));
  localparam logic [WIDTH-1:0]        Z_DIR  = WIDTH'(-int'(FOCAL));

  raygen_state_t  state_q, state_d;
  logic           start_d, busy_d, done_d;
  ray_direction_t ray_d;

  logic           accept, fire;
  logic           x_adv, y_adv;
  logic [XW-1:0]  x_idx;
  logic [YW-1:0]  y_idx;
  logic           x_last, y_last;
  logic [WIDTH-1:0] x_val, y_val;

  ray_axis_stepper #(
    .Count (IMG_W),
    .AccW  (ACC_W),
    .Init  (X0),
    .Step  (X_STEP),
    .Max   (MAX),
    .Min   (MIN)
  ) u_x_axis (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .adv   (x_adv),
    .idx   (x_idx),
    .last  (x_last),
    .value (x_val)
  );

  ray_axis_stepper #(
    .Count (IMG_H),
    .AccW  (ACC_W),
    .Init  (Y0),
    .Step  (Y_STEP),
    .Max   (MAX),
    .Min   (MIN)
  ) u_y_axis (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .adv   (y_adv),
    .idx   (y_idx),
    .last  (y_last),
    .value (y_val)
  );

  // x reloads itself after its last column; y steps exactly when x wraps.
  assign x_adv = fire;
  assign y_adv = fire & x_last;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    ray_d   = ray_out;
    busy_d  = busy;
    done_d  = 1'b0;
    accept  = 1'b0;
    fire    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          accept  = 1'b1;
          busy_d  = 1'b1;
          state_d = StIssue;
          // The accept edge already issues pixel (0,0) when enable is high.
          fire    = enable;
        end
      end
      StIssue: begin
        fire = enable;
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    if (fire) begin
      start_d = 1'b1;
      ray_d.x = x_val;
      ray_d.y = y_val;
      ray_d.z = Z_DIR;
      if (x_last && y_last) begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      start_out  <= 1'b0;
      ray_out    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_out  <= start_d;
      ray_out    <= ray_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

`ifdef RAYGEN_PIXEL_TAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (fire) begin
      pixel_x <= x_idx;
      pixel_y <= y_idx;
    end
  end
`else
  logic unused_idx;
  assign unused_idx = ^{x_idx, y_idx};
`endif

endmodule

// File: tb/tb_ray_dir_generator.sv
// Scoreboard bench for ray_dir_generator: expected rays are queued when a frame
// is started and popped as start_out rays appear. A second instance uses a
// coarse pitch so that both axes saturate.
module tb_ray_dir_generator;
  import ray_dir_generator_pkg::*;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [5:0]  px;
    logic [5:0]  py;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, frame_start, frame_start_w, enable;
  logic start_out, busy, frame_done;
  logic start_out_w, busy_w, frame_done_w;
  ray_direction_t ray_out, ray_out_w;
  logic [5:0] pixel_x, pixel_y, pixel_x_w, pixel_y_w;

  ray_dir_generator dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .enable      (enable),
    .start_out   (start_out),
    .ray_out     (ray_out),
    .busy        (busy),
    .frame_done  (frame_done)
`ifdef RAYGEN_PIXEL_TAG_EN
    ,
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y)
`endif
  );

  ray_dir_generator #(
    .STEP (16'h0800)
  ) dut_w (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start_w),
    .enable      (enable),
    .start_out   (start_out_w),
    .ray_out     (ray_out_w),
    .busy        (busy_w),
    .frame_done  (frame_done_w)
`ifdef RAYGEN_PIXEL_TAG_EN
    ,
    .pixel_x     (pixel_x_w),
    .pixel_y     (pixel_y_w)
`endif
  );

`ifndef RAYGEN_PIXEL_TAG_EN
  assign pixel_x   = '0;
  assign pixel_y   = '0;
  assign pixel_x_w = '0;
  assign pixel_y_w = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  exp_t exp_q[$];
  exp_t exp_w_q[$];
  exp_t e, ew;
  logic [47:0] last_exp_ray;
  int ray_cnt, ray_cnt_w, first_cyc, last_cyc, done_cyc, accept_cyc;
  int n_done = 0;
  int n_done_w = 0;
  int n_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic push_frame(input bit wide, input int step);
    exp_t t;
    int x0, y0;
    x0 = -((63 * step) / 2);
    y0 = (47 * step) / 2;
    for (int j = 0; j < 48; j++) begin
      for (int i = 0; i < 64; i++) begin
        t.x = sat16(x0 + i * step);
        t.y = sat16(y0 - j * step);
        t.z = 16'hF000;
`ifdef RAYGEN_PIXEL_TAG_EN
        t.px = 6'(i);
        t.py = 6'(j);
`else
        t.px = '0;
        t.py = '0;
`endif
        if (wide) exp_w_q.push_back(t);
        else exp_q.push_back(t);
      end
    end
  endtask

  // Main-instance monitor.
  always @(negedge clk) begin
    if (reset) begin
      if (start_out) begin
        if (exp_q.size() == 0) begin
          check("extra_ray", 64'(ray_out), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("ray", 64'({ray_out, pixel_x, pixel_y}), 64'(e));
          last_exp_ray = {e.x, e.y, e.z};
        end
        case (ray_cnt)
          0:    check("first_ray", 64'(ray_out), 64'(48'hF820_05E0_F000));
          63:   check("row_end", 64'(ray_out), 64'(48'h07E0_05E0_F000));
          64:   check("row_wrap", 64'(ray_out), 64'(48'hF820_05A0_F000));
          3071: check("last_ray", 64'(ray_out), 64'(48'h07E0_FA20_F000));
          default: ;
        endcase
        if (ray_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        ray_cnt++;
      end else if (busy && ray_cnt > 0) begin
        check("hold", 64'(ray_out), 64'(last_exp_ray));
        if (ray_cnt < 3072) n_stall++;
      end
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  // Coarse-pitch instance monitor.
  always @(negedge clk) begin
    if (reset) begin
      if (start_out_w) begin
        if (exp_w_q.size() == 0) begin
          check("extra_ray_w", 64'(ray_out_w), 64'(0));
        end else begin
          ew = exp_w_q.pop_front();
          check("ray_w", 64'({ray_out_w, pixel_x_w, pixel_y_w}), 64'(ew));
        end
        case (ray_cnt_w)
          0:    check("clamp_tl_w", 64'(ray_out_w), 64'(48'h8000_7FFF_F000));
          31:   check("mid_w", 64'(ray_out_w), 64'(48'hFC00_7FFF_F000));
          32:   check("mid2_w", 64'(ray_out_w), 64'(48'h0400_7FFF_F000));
          543:  check("unclamped_w", 64'(ray_out_w), 64'(48'hFC00_7C00_F000));
          3071: check("clamp_br_w", 64'(ray_out_w), 64'(48'h7FFF_8000_F000));
          default: ;
        endcase
        ray_cnt_w++;
      end
      if (frame_done_w) n_done_w++;
    end
  end

  task automatic start_frame(input bit wide);
    if (wide) begin
      ray_cnt_w = 0;
      push_frame(1'b1, 2048);
    end else begin
      ray_cnt = 0;
      n_stall = 0;
      push_frame(1'b0, 64);
    end
    @(negedge clk);
    if (wide) frame_start_w = 1'b1;
    else frame_start = 1'b1;
    @(negedge clk);
    frame_start   = 1'b0;
    frame_start_w = 1'b0;
    accept_cyc    = cyc;
    check(wide ? "busy_on_w" : "busy_on", 64'(wide ? busy_w : busy), 64'(1));
  endtask

  task automatic wait_rays(input int n);
    for (int k = 0; k < 5000; k++) begin
      if (ray_cnt >= n) return;
      @(negedge clk);
      #1;
    end
    check("ray_timeout", 64'(ray_cnt), 64'(n));
  endtask

  task automatic wait_done(input bit wide);
    int base;
    base = wide ? n_done_w : n_done;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      #1;
      if ((wide ? n_done_w : n_done) > base) return;
    end
    check("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int n0;
    reset         = 1'b0;
    frame_start   = 1'b0;
    frame_start_w = 1'b0;
    enable        = 1'b1;
    ray_cnt       = 0;
    ray_cnt_w     = 0;
    n_stall       = 0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({start_out, busy, frame_done, ray_out}), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Full frame with enable held high.
    start_frame(1'b0);
    wait_done(1'b0);
    check("first_latency", 64'(first_cyc), 64'(accept_cyc));
    check("consecutive", 64'(last_cyc - first_cyc), 64'(3071));
    check("ray_count", 64'(ray_cnt), 64'(3072));
    check("done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
    check("busy_off", 64'({busy, frame_done, start_out}), 64'(3'b010));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    // Five stalled cycles after ten rays.
    start_frame(1'b0);
    wait_rays(10);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_done(1'b0);
    check("stall_cycles", 64'(n_stall), 64'(5));
    check("ray_count_stall", 64'(ray_cnt), 64'(3072));
    check("queue_empty_stall", 64'(exp_q.size()), 64'(0));

    // frame_start during ISSUE and during DONE is ignored.
    start_frame(1'b0);
    wait_rays(200);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n0 = n_done;
    wait_rays(3072);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("single_done", 64'(n_done - n0), 64'(1));
    check("idle_after_done", 64'({busy, start_out}), 64'(0));
    check("ray_count_ign", 64'(ray_cnt), 64'(3072));

    // Mid-frame asynchronous reset, then a fresh frame from pixel (0,0).
    start_frame(1'b0);
    wait_rays(100);
    reset = 1'b0;
    #1;
    check("async_reset", 64'({start_out, busy, frame_done, ray_out}), 64'(0));
    n0 = n_done;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("no_done_on_abort", 64'(n_done), 64'(n0));
    check("idle_after_abort", 64'({busy, start_out}), 64'(0));
    start_frame(1'b0);
    wait_done(1'b0);
    check("ray_count_restart", 64'(ray_cnt), 64'(3072));

    // Coarse pitch: saturation on both axes.
    start_frame(1'b1);
    wait_done(1'b1);
    check("ray_count_w", 64'(ray_cnt_w), 64'(3072));
    check("queue_empty_w", 64'(exp_w_q.size()), 64'(0));
    check("busy_off_w", 64'(busy_w), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
